// File: rtl/led_share_arbiter_if.sv
// Bundle between the LED pattern requesters and the LED share arbiter.
// A requester holds req high for as long as it wants the LEDs; gnt (one-hot or zero) names the single holder; dropping req releases.
interface led_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] pat;
  logic [NUM_REQ-1:0]   gnt;
  logic [3:0]           led;
  logic                 tick;

  modport master (output req, output pat, input gnt, input led, input tick);
  modport slave  (input req, input pat, output gnt, output led, output tick);
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the four board LEDs plus the free-running system slow-tick prescaler.
// Optional feature macro LED_ROTATE_EN: rotating one-hot idle pattern instead of IDLE_PATTERN.
module led_share_arbiter #(
  parameter int         CLK_HZ       = 100_000_000,
  parameter int         TICK_HZ      = 1,
  parameter int         NUM_REQ      = 4,
  parameter int         HOLD_TICKS   = 3,
  parameter logic [3:0] IDLE_PATTERN = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_share_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state_o
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(NUM_REQ);
  localparam int HW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       pre_q;
  logic                tick_q;
  logic [HW-1:0]       hold_q, hold_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       holder_q, holder_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [3:0]          led_q, led_d;
  logic [3:0]          idle_led;
  logic                found;
  logic [IW-1:0]       win;
  logic [IW-1:0]       cand;

  // Prescaler runs regardless of grants; tick is registered off the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (pre_q == PRE_LAST);
      pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + CW'(1);
    end
  end

`ifdef LED_ROTATE_EN
  logic [3:0] rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 4'b0001;
    end else if (tick_q) begin
      rot_q <= {rot_q[2:0], rot_q[3]};
    end
  end

  assign idle_led = rot_q;
`else
  assign idle_led = IDLE_PATTERN;
`endif

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    ptr_d    = ptr_q;
    holder_d = holder_q;
    gnt_d    = '0;
    led_d    = idle_led;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          led_d    = bus.pat[{win, 2'b00} +: 4];
          hold_d   = '0;
          holder_d = win;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A drop and an expiry in the same cycle collapse into one release.
        if (!bus.req[holder_q] || (tick_q && (hold_q == HOLD_LAST))) begin
          ptr_d   = (holder_q == IDX_LAST) ? '0 : holder_q + IW'(1);
          state_d = ST_GAP;
        end else begin
          gnt_d = gnt_q;
          led_d = bus.pat[{holder_q, 2'b00} +: 4];
          if (tick_q) begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      ptr_q    <= '0;
      holder_q <= '0;
      gnt_q    <= '0;
      led_q    <= IDLE_PATTERN;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
      holder_q <= holder_d;
      gnt_q    <= gnt_d;
      led_q    <= led_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.led     = led_q;
  assign bus.tick    = tick_q;
  assign dbg_state_o = state_q;
endmodule
